// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared widths, FIFO defaults and the push/pop arbitration helper.
// Rev 1.0
`default_nettype none

package uart_rx_fifo_pkg;

  localparam int BYTE_W        = 8;
  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_AW    = 4;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef struct packed {
    logic wr;
    logic rd;
    logic drop;
  } fifo_op_t;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is kept when it coincides with a pop.
  function automatic fifo_op_t fifo_op(input logic push, input logic rd_req,
                                       input logic empty, input logic full);
    fifo_op_t op;
    op.rd   = rd_req & ~empty;
    op.wr   = push & (~full | op.rd);
    op.drop = push & full & ~op.rd;
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side byte capture and consumer read port of the RX FIFO.
// Rev 1.0
`default_nettype none

interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int AW = RX_FIFO_AW
);

  logic          i_rx_done;
  byte_t         i_rx_result;
  logic          i_rd_ready;
  logic          i_clr_overflow;
  logic          o_rd_valid;
  byte_t         o_rd_data;
  logic [AW:0]   o_count;
  logic          o_overflow;

  modport slave (
    input  i_rx_done, i_rx_result, i_rd_ready, i_clr_overflow,
    output o_rd_valid, o_rd_data, o_count, o_overflow
  );

  modport master (
    output i_rx_done, i_rx_result, i_rd_ready, i_clr_overflow,
    input  o_rd_valid, o_rd_data, o_count, o_overflow
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo_sync_2ff.sv
// sync_2ff: two-flop single-bit synchroniser with a configurable reset value.
// Rev 1.0
`default_nettype none

module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_d,
  output logic      o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures each completed UART byte on the rx_done rising edge into a FWFT FIFO.
// Rev 1.0
`default_nettype none

module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int AW    = RX_FIFO_AW
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  uart_rx_fifo_if.slave   bus
);

  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  logic          w_done_s2;
  logic          r_done_s3;
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  fifo_op_t      w_op;

  byte_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  sync_2ff #(.RST_VAL(1'b1)) u_done_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.i_rx_done),
    .o_q   (w_done_s2)
  );

  // Data is not synchronised: the receiver holds rx_result for a baud period after done rises.
  assign w_push  = w_done_s2 & ~r_done_s3;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);
  assign w_op    = fifo_op(w_push, bus.i_rd_ready, w_empty, w_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_s3  <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done_s3 <= w_done_s2;
      if (w_op.wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_op.rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_op.wr && !w_op.rd)      r_count <= r_count + 1'b1;
      else if (w_op.rd && !w_op.wr) r_count <= r_count - 1'b1;
      if (w_op.drop)                r_overflow <= 1'b1;
      else if (bus.i_clr_overflow)  r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_op.wr) r_mem[r_wr_ptr] <= bus.i_rx_result;
  end

  assign bus.o_rd_valid = ~w_empty;
  assign bus.o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.o_count    = r_count;
  assign bus.o_overflow = r_overflow;

endmodule

`default_nettype wire
